uart_rx_cfg: RTL and testbench

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity and stop bits, and 3-point majority-vote sampling. Reports framing, parity, overrun and break status. Delivers characters through a valid/ready holding register. Sits between the board RX pin and a byte consumer such as a FIFO or command decoder.

---
 rtl/uart_rx_cfg.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// 3-point majority sampling, framing/parity/break/overrun status and a
// valid/ready holding register toward the consumer.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int unsigned H = CLKS_PER_BIT / 2;
  localparam logic [15:0] CntLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CntS0   = 16'(H - 1);
  localparam logic [15:0] CntS1   = 16'(H);
  localparam logic [15:0] CntRes  = 16'(H + 1);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StPar, StStop, StDeliver, StWaitHigh
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state, w_state_nxt;
  logic [15:0]          r_ccnt, w_ccnt_nxt;
  logic [3:0]           r_bcnt, w_bcnt_nxt;
  logic                 r_s0, w_s0_nxt;
  logic                 r_s1, w_s1_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_ferr, w_ferr_nxt;
  // Any sampled 1 among data, parity and stop bits; a break needs none.
  logic                 r_nz, w_nz_nxt;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_fe, r_pe, r_brk, r_ovr;

  logic w_rxs, w_maj, w_res, w_end, w_perr, w_deliver, w_xfer;

  assign w_rxs = r_sync2;
  assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_res = (r_ccnt == CntRes);
  assign w_end = (r_ccnt == CntLast);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM and bit datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_ccnt  <= '0;
      r_bcnt  <= '0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ferr  <= 1'b0;
      r_nz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_s0    <= w_s0_nxt;
      r_s1    <= w_s1_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_ferr  <= w_ferr_nxt;
      r_nz    <= w_nz_nxt;
    end
  end

  // Next-state logic: bit timing, majority resolution and frame sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_ccnt_nxt  = r_ccnt;
    w_bcnt_nxt  = r_bcnt;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_ferr_nxt  = r_ferr;
    w_nz_nxt    = r_nz;

    if (r_state inside {StStart, StData, StPar, StStop}) begin
      w_ccnt_nxt = w_end ? 16'd0 : r_ccnt + 16'd1;
      if (r_ccnt == CntS0) w_s0_nxt = w_rxs;
      if (r_ccnt == CntS1) w_s1_nxt = w_rxs;
    end

    unique case (r_state)
      StIdle: begin
        w_ccnt_nxt = '0;
        w_bcnt_nxt = '0;
        w_ferr_nxt = 1'b0;
        w_nz_nxt   = 1'b0;
        if (!w_rxs) w_state_nxt = StStart;
      end
      StStart: begin
        if (w_res && w_maj) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          w_state_nxt = StIdle;
          w_ccnt_nxt  = '0;
        end else if (w_end) begin
          w_state_nxt = StData;
        end
      end
      StData: begin
        if (w_res) begin
          w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
          w_nz_nxt    = r_nz | w_maj;
        end
        if (w_end) begin
          if (r_bcnt == DataLast) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = (PARITY != 0) ? StPar : StStop;
          end else begin
            w_bcnt_nxt = r_bcnt + 4'd1;
          end
        end
      end
      StPar: begin
        if (w_res) begin
          w_par_nxt = w_maj;
          w_nz_nxt  = r_nz | w_maj;
        end
        if (w_end) w_state_nxt = StStop;
      end
      StStop: begin
        if (w_res) begin
          if (!w_maj) w_ferr_nxt = 1'b1;
          w_nz_nxt = r_nz | w_maj;
          if (r_bcnt == StopLast) begin
            // Deliver at mid-bit so the next start edge is never missed.
            w_state_nxt = StDeliver;
            w_ccnt_nxt  = '0;
          end
        end
        if (w_end) w_bcnt_nxt = r_bcnt + 4'd1;
      end
      StDeliver: begin
        w_ccnt_nxt  = '0;
        w_state_nxt = r_ferr ? StWaitHigh : StIdle;
      end
      StWaitHigh: begin
        if (w_rxs) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Parity check of the assembled character.
  always_comb begin
    w_perr = 1'b0;
    if (PARITY == 1) begin
      w_perr = ~(^{r_shift, r_par});
    end else if (PARITY == 2) begin
      w_perr = ^{r_shift, r_par};
    end
  end

  assign w_deliver = (r_state == StDeliver);
  assign w_xfer    = r_valid & i_ready;

  // Holding register: loads when empty or draining this cycle, else drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_deliver && (!r_valid || i_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_fe    <= r_ferr;
        r_pe    <= w_perr;
        r_brk   <= r_ferr & ~r_nz;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_deliver && r_valid && !i_ready) begin
        r_ovr <= 1'b1;
      end else if (w_xfer) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_fe;
  assign o_parity_err = r_pe;
  assign o_break      = r_brk;
  assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both
// at 16 clocks per bit. Stimulus pushes expected characters; monitors pop and
// compare on every transfer.
module tb_uart_rx_cfg;

  localparam int Cpb = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic       a_valid, a_fe, a_pe, a_brk, a_ovr;
  logic       b_valid, b_fe, b_pe, b_brk, b_ovr;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rstn(rstn), .i_rx(rx_a), .o_data(a_data), .o_valid(a_valid),
    .i_ready(ready_a), .o_frame_err(a_fe), .o_parity_err(a_pe), .o_break(a_brk),
    .o_overrun(a_ovr)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rstn(rstn), .i_rx(rx_b), .o_data(b_data), .o_valid(b_valid),
    .i_ready(ready_b), .o_frame_err(b_fe), .o_parity_err(b_pe), .o_break(b_brk),
    .o_overrun(b_ovr)
  );

  function automatic exp_t mk(input logic [8:0] d, input logic fe, input logic pe,
                              input logic brk, input logic ovr);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe; e.brk = brk; e.ovr = ovr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (rstn && a_valid && ready_a) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_unexpected: got data 0x%0h with no character expected", a_data);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_data", 32'(a_data), 32'(e.data));
        chk("a_frame_err", 32'(a_fe), 32'(e.fe));
        chk("a_parity_err", 32'(a_pe), 32'(e.pe));
        chk("a_break", 32'(a_brk), 32'(e.brk));
        chk("a_overrun", 32'(a_ovr), 32'(e.ovr));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && b_valid && ready_b) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected: got data 0x%0h with no character expected", b_data);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_data", 32'(b_data), 32'(e.data));
        chk("b_frame_err", 32'(b_fe), 32'(e.fe));
        chk("b_parity_err", 32'(b_pe), 32'(e.pe));
        chk("b_break", 32'(b_brk), 32'(e.brk));
        chk("b_overrun", 32'(b_ovr), 32'(e.ovr));
      end
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Send one frame LSB-first. glitch_bit inverts one clock near mid-bit of that
  // frame bit; stop_after aborts after that many clocks (-1 = full frame).
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic pb, input int nstop,
                            input int glitch_bit, input int stop_after);
    logic [15:0] f;
    logic        v;
    int          n;
    int          cyc;
    f = '1;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      f[n] = d[i]; n++;
    end
    if (has_par) begin
      f[n] = pb; n++;
    end
    for (int s = 0; s < nstop; s++) begin
      f[n] = 1'b1; n++;
    end
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < Cpb; c++) begin
        if (stop_after >= 0 && cyc >= stop_after) return;
        v = f[b];
        // Cycle 9 of the bench bit lines up with the middle sample after sync.
        if (b == glitch_bit && c == 9) v = ~v;
        drive(sel, v);
        @(posedge clk); #1;
        cyc++;
      end
    end
    drive(sel, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    idle(4);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_b_flags", {28'd0, b_fe, b_pe, b_brk, b_ovr}, 32'd0);
    rstn = 1'b1;
    idle(4);

    // 8N1 basic character.
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, -1, -1);
    idle(4);

    // 7E2: correct parity, then wrong parity.
    q_b.push_back(mk(9'h035, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b1, 9'h035, 7, 1'b1, 1'b0, 2, -1, -1);
    idle(4);
    q_b.push_back(mk(9'h035, 1'b0, 1'b1, 1'b0, 1'b0));
    send_frame(1'b1, 9'h035, 7, 1'b1, 1'b1, 2, -1, -1);
    idle(4);

    // Break: line low for 15 bit times gives a single break character.
    q_a.push_back(mk(9'h000, 1'b1, 1'b0, 1'b1, 1'b0));
    rx_a = 1'b0;
    idle(15 * Cpb);
    rx_a = 1'b1;
    idle(10 * Cpb);

    // Short start pulse is rejected: nothing is queued for it.
    rx_a = 1'b0;
    idle(5);
    rx_a = 1'b1;
    idle(3 * Cpb);

    // Single-clock glitch on data bit 0 is outvoted.
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1, -1);
    idle(4);
    q_a.push_back(mk(9'h05A, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, 3, -1);
    idle(4);

    // Overrun: hold off the consumer across three characters.
    ready_a = 1'b0;
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, -1, -1);
    idle(2);
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, -1, -1);
    idle(2);
    send_frame(1'b0, 9'h033, 8, 1'b0, 1'b0, 1, -1, -1);
    idle(4);
    chk("ovr_held_data", 32'(a_data), 32'h11);
    chk("ovr_valid", 32'(a_valid), 32'd1);
    chk("ovr_sticky", 32'(a_ovr), 32'd1);
    q_a.push_back(mk(9'h011, 1'b0, 1'b0, 1'b0, 1'b1));
    ready_a = 1'b1;
    @(posedge clk); #1;
    ready_a = 1'b0;
    chk("ovr_valid_after_xfer", 32'(a_valid), 32'd0);
    chk("ovr_clear_after_xfer", 32'(a_ovr), 32'd0);
    idle(2);
    ready_a = 1'b1;
    q_a.push_back(mk(9'h044, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b0, 9'h044, 8, 1'b0, 1'b0, 1, -1, -1);
    idle(4);

    // Reset in the middle of data bit 4 of 0x5A (start + 4 bits + half a bit).
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, -1, 5 * Cpb + 8);
    rstn = 1'b0;
    #1;
    chk("midrst_data", 32'(a_data), 32'd0);
    chk("midrst_valid", 32'(a_valid), 32'd0);
    chk("midrst_flags", {28'd0, a_fe, a_pe, a_brk, a_ovr}, 32'd0);
    rx_a = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(4);
    q_a.push_back(mk(9'h0C3, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1, -1, -1);

    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    idle(3 * Cpb);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
